// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier: {HI, LO} product of two WIDTH-bit operands.
// Define BOOTH_MUL_RADIX4_EN for radix-4 recoding (WIDTH/2 iterations); default is radix-2 (WIDTH iterations).
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  // Two guard bits keep +/-2M from wrapping the accumulator.
  localparam int AW = WIDTH + 2;
`ifdef BOOTH_MUL_RADIX4_EN
  localparam int ITER = WIDTH / 2;
  localparam int SH   = 2;
`else
  localparam int ITER = WIDTH;
  localparam int SH   = 1;
`endif
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic signed [AW-1:0] m;
  logic signed [AW-1:0] a;
  logic [WIDTH-1:0]     q;
  logic                 qm1;

  logic signed [AW-1:0] a_sum;
  logic signed [AW-1:0] a_nxt;
  logic [WIDTH-1:0]     q_nxt;
  logic                 qm1_nxt;

`ifdef BOOTH_MUL_RADIX4_EN
  function automatic logic signed [AW-1:0] booth_recode(input logic [2:0] bits,
                                                        input logic signed [AW-1:0] mm);
    case (bits)
      3'b001, 3'b010: booth_recode = mm;
      3'b011:         booth_recode = mm <<< 1;
      3'b100:         booth_recode = -(mm <<< 1);
      3'b101, 3'b110: booth_recode = -mm;
      default:        booth_recode = '0;
    endcase
  endfunction
`else
  function automatic logic signed [AW-1:0] booth_recode(input logic [1:0] bits,
                                                        input logic signed [AW-1:0] mm);
    case (bits)
      2'b01:   booth_recode = mm;
      2'b10:   booth_recode = -mm;
      default: booth_recode = '0;
    endcase
  endfunction
`endif

  always_comb begin
    a_sum   = a + booth_recode({q[SH-1:0], qm1}, m);
    a_nxt   = a_sum >>> SH;
    q_nxt   = {a_sum[SH-1:0], q[WIDTH-1:SH]};
    qm1_nxt = q[SH-1];
  end

  // Datapath: operand capture on acceptance, one recoded step per RUN cycle.
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      if (start) begin
        m   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
        a   <= '0;
        q   <= multiplier;
        qm1 <= 1'b0;
      end
    end else begin
      a   <= a_nxt;
      q   <= q_nxt;
      qm1 <= qm1_nxt;
    end
  end

  // Control: state, iteration counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            out   <= {a_nxt[WIDTH-1:0], q_nxt};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed vectors, multi-cycle corner sequences, random pairs.
module tb_booth_multiplier;

`ifdef BOOTH_MUL_RADIX4_EN
  localparam int ITER = 16;
`else
  localparam int ITER = 32;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] out;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  booth_multiplier #(.WIDTH(32)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .out(out)
  );

  typedef struct {
    string       name;
    logic [31:0] mc;
    logic [31:0] mp;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Start one operation from idle; returns at the negedge where done is seen (or on timeout).
  task automatic mul(input logic [31:0] mc, input logic [31:0] mp,
                     output logic [63:0] res, output int lat, output int busy_cyc);
    @(negedge clock);
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cyc++;
      @(negedge clock);
      lat++;
    end
    res = out;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic [63:0] res;
    int          lat, bc, n, dones, holds;
    logic [31:0] x, y;

    vecs[0] = '{"7x-3",       32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{"min x min",  32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{"min x 1",    32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000};
    vecs[3] = '{"max x max",  32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[4] = '{"-1 x -1",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'd1};
    vecs[5] = '{"0 x -5",     32'd0,          32'hFFFF_FFFB, 64'd0};
    vecs[6] = '{"1 x min",    32'd1,          32'h8000_0000, 64'hFFFF_FFFF_8000_0000};

    // Reset state
    repeat (2) @(negedge clock);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out",  out,       64'd0);
    reset_n = 1'b1;

    // Latency and busy width for 7 x -3
    mul(32'd7, 32'hFFFF_FFFD, res, lat, bc);
    check("7x-3 out", res, 64'hFFFF_FFFF_FFFF_FFEB);
    check("7x-3 latency", 64'(lat), 64'(ITER));
    check("7x-3 busy cycles", 64'(bc), 64'(ITER));
    @(negedge clock);
    check("done one cycle", 64'(done), 64'd0);
    check("out holds", out, 64'hFFFF_FFFF_FFFF_FFEB);

    for (int i = 0; i < 7; i++) begin
      mul(vecs[i].mc, vecs[i].mp, res, lat, bc);
      check(vecs[i].name, res, vecs[i].exp);
    end

    // Start mid-run and operand changes after capture are ignored
    @(negedge clock);
    multiplicand = 32'd6;
    multiplier   = 32'd5;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    multiplicand = 32'd2;
    multiplier   = 32'd2;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    wait_done(n);
    check("ignored start out", out, 64'd30);
    dones = 0;
    repeat (ITER + 4) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("no extra done", 64'(dones), 64'd0);

    // Back-to-back: new start during the done cycle
    @(negedge clock);
    multiplicand = 32'd3;
    multiplier   = 32'd4;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
    check("b2b first out", out, 64'd12);
    multiplicand = 32'd12;
    multiplier   = 32'hFFFF_FFF4;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("b2b done falls", 64'(done), 64'd0);
    check("b2b busy", 64'(busy), 64'd1);
    n     = 0;
    holds = 1;
    while (!done && n < 200) begin
      if (out !== 64'd12) holds = 0;
      @(negedge clock);
      n++;
    end
    check("b2b hold", 64'(holds), 64'd1);
    check("b2b latency", 64'(n), 64'(ITER));
    check("b2b second out", out, 64'hFFFF_FFFF_FFFF_FF70);

    // Reset mid-operation aborts with no done
    @(negedge clock);
    multiplicand = 32'd7;
    multiplier   = 32'hFFFF_FFFD;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort out",  out,       64'd0);
    dones = 0;
    repeat (ITER) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    reset_n = 1'b1;
    mul(32'd7, 32'hFFFF_FFFD, res, lat, bc);
    check("after abort 7x-3", res, 64'hFFFF_FFFF_FFFF_FFEB);

    // Random signed pairs with biased extremes
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       x = 32'h8000_0000;
        1:       x = 32'h7FFF_FFFF;
        2:       x = 32'hFFFF_FFFF;
        3:       x = 32'd0;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'h8000_0000;
        1:       y = 32'h7FFF_FFFF;
        2:       y = 32'hFFFF_FFFF;
        3:       y = 32'd0;
        default: y = $urandom;
      endcase
      mul(x, y, res, lat, bc);
      check("random", res, ref_mul(x, y));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
